// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic/ADC operations plus a WIDTH-cycle
// unsigned shift-add multiplier, with registered result and flags.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_ADC = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH:0]   alu_sum;
    logic             alu_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // Single-cycle datapath; bit WIDTH of alu_sum is the carry-out.
    always_comb begin
        alu_sum = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_sum = {1'b0, a} + {1'b0, b};
                alu_ovf = (a[MSB] == b[MSB]) && (alu_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
                alu_ovf = (a[MSB] != b[MSB]) && (alu_sum[MSB] != a[MSB]);
            end
            OP_AND: alu_sum = {1'b0, a & b};
            OP_OR:  alu_sum = {1'b0, a | b};
            OP_XOR: alu_sum = {1'b0, a ^ b};
            OP_ADC: begin
                alu_sum = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(carry_q);
                alu_ovf = (a[MSB] == b[MSB]) && (alu_sum[MSB] != a[MSB]);
            end
            default: begin
                alu_sum = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // One shift-add step: conditionally add multiplicand, shift {acc,mplier} right.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        busy_d   = 1'b1;
                        mcand_d  = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        done_d   = 1'b1;
                        res_d    = alu_sum[WIDTH-1:0];
                        res_hi_d = '0;
                        carry_d  = alu_sum[WIDTH];
                        ovf_d    = alu_ovf;
                        zero_d   = (alu_sum[WIDTH-1:0] == '0);
                        neg_d    = alu_sum[MSB];
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_hi;
                mplier_d = mul_lo;
                cnt_d    = cnt_q + CW'(1);
                // Final iteration edge also commits the product.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    res_d    = mul_lo;
                    res_hi_d = mul_hi;
                    zero_d   = ({mul_hi, mul_lo} == '0);
                    neg_d    = mul_hi[MSB];
                    carry_d  = (mul_hi != '0);
                    ovf_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign res    = res_q;
    assign res_hi = res_hi_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=4).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port: op  input  3  operation code, sampled with start.
REQ-006 SHALL have ports: a, b  input  WIDTH  operands, sampled with start.
REQ-007 SHALL have port: busy  output  1  multi-cycle operation in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have ports: res, res_hi  output  WIDTH  result low word, MUL high word.
REQ-010 SHALL have ports: carry, zero, neg, ovf  output  1 each  registered flags.

Function
REQ-011 SHALL decode op as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADC, 6 MUL, 7 reserved.
REQ-012 SHALL implement states IDLE, MUL; IDLE->MUL on accepted start with op=6; MUL->IDLE after WIDTH iteration edges.
REQ-013 SHALL, for op!=6 accepted at edge k, register res/res_hi/flags at edge k and drive done=1 for the cycle after edge k (latency 1, busy stays 0).
REQ-014 SHALL compute ADD as {carry,res}=a+b; SUB as a+~b+1 with carry=1 meaning no borrow; ADC as a+b+carry (stored flag value before edge k).
REQ-015 SHALL set ovf for ADD/ADC when a,b MSBs equal and res MSB differs; for SUB when a,b MSBs differ and res MSB differs from a MSB.
REQ-016 SHALL, for AND/OR/XOR, set carry=0, ovf=0; res_hi=0 for all ops except MUL.
REQ-017 SHALL, for op 7, set res=0, res_hi=0, zero=1, carry=neg=ovf=0, latency 1.
REQ-018 SHALL set zero=(res==0) and neg=res[WIDTH-1] for all ops except MUL.
REQ-019 SHALL compute MUL as unsigned shift-add, one partial product per edge, operands latched at edge k.
REQ-020 SHALL drive busy=1 from after edge k through edge k+WIDTH, register {res_hi,res}=a*b at edge k+WIDTH, done=1 for the cycle after edge k+WIDTH.
REQ-021 SHALL set MUL flags: zero=({res_hi,res}==0), neg=res_hi[WIDTH-1], carry=(res_hi!=0), ovf=0.
REQ-022 SHALL ignore start while busy=1; operands/op changes during MUL SHALL not affect the result.
REQ-023 SHALL accept start in the same cycle done=1 (back-to-back, no idle cycle).
REQ-024 SHALL hold res/res_hi/flags stable between completions; done SHALL never be high two consecutive cycles for a single op.

Reset
REQ-025 SHALL, on rst_n=0, immediately force state IDLE, busy=0, done=0, res=0, res_hi=0, carry=0, neg=0, ovf=0, zero=1, iteration counter=0.
REQ-026 SHALL abandon an in-progress MUL on reset with no done pulse; first edge after rst_n release with start=1 SHALL be accepted.

Verification (WIDTH=8)
REQ-027 SHALL verify SUB a=3,b=2 -> next cycle done=1, res=1, carry=1, zero=0, ovf=0; then ADD a=3,b=2 -> res=5, carry=0.
REQ-028 SHALL verify ADD a=200,b=100 -> res=44, carry=1, ovf=0; then ADC a=0,b=0 -> res=1, carry=0.
REQ-029 SHALL verify ADD a=100,b=50 -> res=150, neg=1, ovf=1; SUB a=5,b=5 -> res=0, zero=1, carry=1.
REQ-030 SHALL verify MUL a=255,b=255 -> busy for 8 cycles, then done=1, res=0x01, res_hi=0xFE, carry=1; start pulses with op=0 during busy produce no done.
REQ-031 SHALL verify rst_n=0 asserted 3 cycles into MUL -> busy=0, done=0, res=0, zero=1 immediately; no later done until a new start.
REQ-032 SHALL verify back-to-back: XOR a=0xF0,b=0xFF issued in done cycle of prior MUL -> next cycle res=0x0F, res_hi=0, carry=0.
